// File: rtl/bram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_frame_reader
// Function : Reads one RGB565 frame from a single-port image BRAM, starting at
//            BASE_ADDR. It presents the pixels as a valid/ready stream with
//            x/y coordinates.
//            A 4-entry prefetch FIFO absorbs the 2-edge BRAM read latency and
//            downstream stalls, so the reader streams 1 pixel/cycle while the
//            sink keeps pix_ready high.
// Options  : FRAME_LOOP_EN - if start is high at the final read issue, the
//            reader continues seamlessly into the next frame.
// Revision : 1.0 - initial release
// ============================================================================
module bram_frame_reader #(
  parameter int N         = 13,
  parameter int W         = 16,
  parameter int WIDTH     = 96,
  parameter int HEIGHT    = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  output logic [N-1:0] mem_addr,
  output logic         mem_rw,
  input  logic [W-1:0] mem_data,
  output logic [W-1:0] pix_data,
  output logic [6:0]   pix_x,
  output logic [5:0]   pix_y,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         busy,
  output logic         frame_done
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] C_TOTAL  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [6:0]       C_X_LAST = 7'(WIDTH - 1);
  localparam logic [5:0]       C_Y_LAST = 6'(HEIGHT - 1);
  localparam logic [N-1:0]     C_BASE   = N'(BASE_ADDR);
  localparam logic [2:0]       C_DEPTH  = 3'd4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             loop_q, loop_d;     // next frame already being issued
  logic [N-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;       // reads issued in the current frame
  logic             rd1_q, rd2_q;       // read in flight: address / data stage
  logic [W-1:0]     fifo_q [4];
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       count_q, count_d;
  logic [6:0]       x_q, x_d;
  logic [5:0]       y_q, y_d;

  logic             issue, push, pop, wrap, last_pix;
  logic [CNT_W-1:0] idx;
  logic [2:0]       occ;

  // A start in IDLE always begins at pixel 0, whatever the counter holds.
  assign idx   = (state_q == S_IDLE) ? '0 : cnt_q;
  assign occ   = count_q + {2'b00, rd1_q} + {2'b00, rd2_q};
  assign issue = (state_q == S_IDLE) ? start
               : ((occ < C_DEPTH) && (cnt_q < C_TOTAL));
  assign push  = rd2_q;
  assign pop   = pix_valid & pix_ready;
  assign last_pix = pop && (x_q == C_X_LAST) && (y_q == C_Y_LAST);

`ifdef FRAME_LOOP_EN
  assign wrap = issue && (idx == C_LAST) && start;
`else
  assign wrap = 1'b0;
`endif

  assign mem_addr   = addr_q;
  assign mem_rw     = 1'b0;
  assign pix_valid  = (count_q != 3'd0);
  assign pix_data   = fifo_q[rd_ptr_q];
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign busy       = (state_q == S_RUN);
  assign frame_done = done_q;

  // FSM next state: leave RUN on the last handshake unless a looped frame is queued.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    loop_d  = loop_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (last_pix) begin
          done_d = 1'b1;
          if (loop_q) loop_d = 1'b0;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wrap) loop_d = 1'b1;
  end

  // Datapath next state: read issue, FIFO occupancy and pixel coordinates.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    if (issue) begin
      addr_d = C_BASE + N'(idx);
      cnt_d  = wrap ? '0 : (idx + C_ONE);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      if (x_q == C_X_LAST) begin
        x_d = '0;
        y_d = (y_q == C_Y_LAST) ? 6'd0 : (y_q + 6'd1);
      end else begin
        x_d = x_q + 7'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      loop_q  <= loop_d;
    end
  end

  // Read-issue pipeline and coordinate registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= C_BASE;
      cnt_q   <= '0;
      rd1_q   <= 1'b0;
      rd2_q   <= 1'b0;
      count_q <= 3'd0;
      x_q     <= 7'd0;
      y_q     <= 6'd0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rd1_q   <= issue;
      rd2_q   <= rd1_q;
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Prefetch FIFO storage; capture BRAM data two edges after the issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_data;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_frame_reader
// Function : Scoreboard bench for bram_frame_reader. It loads the BRAM model
//            with mem[a]=a and pushes the expected (data,x,y) of every pixel
//            into a queue. Each task pops and compares one entry per handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_frame_reader;

  localparam int N      = 13;
  localparam int W      = 16;
  localparam int WIDTH  = 96;
  localparam int HEIGHT = 64;
  localparam int BASE   = 0;
  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int LIM    = TOTAL + 40;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] mem_addr;
  logic         mem_rw;
  logic [W-1:0] mem_data;
  logic [W-1:0] pix_data;
  logic [6:0]   pix_x;
  logic [5:0]   pix_y;
  logic         pix_valid;
  logic         pix_ready = 1'b0;
  logic         busy;
  logic         frame_done;

  logic [W-1:0] mem [2**N];
  logic [28:0]  sb [$];
  int vectors = 0;
  int miscompares = 0;
  int rw_bad = 0;

  bram_frame_reader #(.N(N), .W(W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_data(mem_data),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read, one edge after the address is sampled.
  always @(posedge clk) mem_data <= mem[mem_addr];

  always @(negedge clk) if (mem_rw !== 1'b0) rw_bad++;

  initial for (int a = 0; a < 2**N; a++) mem[a] = W'(a);

  task automatic push_frame();
    for (int k = 0; k < TOTAL; k++)
      sb.push_back({W'(BASE + k), 7'(k % WIDTH), 6'(k / WIDTH)});
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    #1;
    vectors++;
    if ({mem_addr, mem_rw, pix_data, pix_x, pix_y, pix_valid, busy, frame_done} !==
        {N'(BASE), 1'b0, 16'd0, 7'd0, 6'd0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_outputs: got addr=%0d rw=%b d=%0d x=%0d y=%0d v=%b busy=%b done=%b, want all zero",
               mem_addr, mem_rw, pix_data, pix_x, pix_y, pix_valid, busy, frame_done);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [28:0] exp;
    int cyc = 0, done_cnt = 0, first = -1;
    push_frame();
    pix_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < LIM; i++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (busy) cyc++;
      if (frame_done) done_cnt++;
      if (pix_valid && first < 0) first = i;
      if (pix_valid && pix_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL full_extra: got pixel %0d at (%0d,%0d), want none", pix_data, pix_x, pix_y);
        end else begin
          exp = sb.pop_front();
          if ({pix_data, pix_x, pix_y} !== exp) begin
            miscompares++;
            $display("FAIL full_pixel: got %0d (%0d,%0d) want %0d (%0d,%0d)",
                     pix_data, pix_x, pix_y, exp[28:13], exp[12:6], exp[5:0]);
          end
        end
      end
      if (done_cnt > 0 && !busy) break;
    end
    vectors++;
    if (first != 2) begin miscompares++; $display("FAIL full_latency: got first valid %0d cycles after start, want 2", first); end
    vectors++;
    if (cyc != TOTAL + 2) begin miscompares++; $display("FAIL full_busy_cycles: got %0d want %0d", cyc, TOTAL + 2); end
    vectors++;
    if (done_cnt != 1 || busy !== 1'b0) begin miscompares++; $display("FAIL full_done: got %0d pulses busy=%b, want 1 and 0", done_cnt, busy); end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL full_missing: got %0d pixels unseen, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_backpressure();
    logic [28:0] exp;
    int h = 0, stall = 0, done_cnt = 0, issued;
    push_frame();
    pix_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < 4 * TOTAL; i++) begin
      @(posedge clk); #1 start = 1'b0;
      if (h < 100) pix_ready = 1'b1;
      else if (stall < 10) begin pix_ready = 1'b0; stall++; end
      else pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy) begin
        issued = int'(mem_addr) - BASE + 1;
        if (issued - h > 4) begin
          vectors++; miscompares++;
          $display("FAIL bp_occupancy: got %0d outstanding reads, want <= 4", issued - h);
        end
      end
      if (frame_done) done_cnt++;
      if (pix_valid && !pix_ready && sb.size() != 0) begin
        vectors++;
        if ({pix_data, pix_x, pix_y} !== sb[0]) begin
          miscompares++;
          $display("FAIL bp_stall_stable: got %0d (%0d,%0d) want %0d (%0d,%0d)",
                   pix_data, pix_x, pix_y, sb[0][28:13], sb[0][12:6], sb[0][5:0]);
        end
      end
      if (pix_valid && pix_ready) begin
        vectors++;
        h++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra: got pixel %0d, want none", pix_data);
        end else begin
          exp = sb.pop_front();
          if ({pix_data, pix_x, pix_y} !== exp) begin
            miscompares++;
            $display("FAIL bp_pixel: got %0d (%0d,%0d) want %0d (%0d,%0d)",
                     pix_data, pix_x, pix_y, exp[28:13], exp[12:6], exp[5:0]);
          end
        end
      end
      if (done_cnt > 0 && !busy) break;
    end
    pix_ready = 1'b1;
    vectors++;
    if (done_cnt != 1 || busy !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_end: got %0d pulses busy=%b %0d unseen, want 1, 0, 0", done_cnt, busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_start_handling();
    logic [28:0] exp;
    int done_cnt;
    for (int f = 0; f < 2; f++) begin
      done_cnt = 0;
      push_frame();
      pix_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      for (int i = 0; i < LIM; i++) begin
        @(posedge clk); #1;
        start = (f == 0) && ((i % 1000 == 500) || (sb.size() == 1));
        @(negedge clk);
        if (frame_done) done_cnt++;
        if (pix_valid && pix_ready) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL start_extra: got pixel %0d, want none", pix_data);
          end else begin
            exp = sb.pop_front();
            if ({pix_data, pix_x, pix_y} !== exp) begin
              miscompares++;
              $display("FAIL start_pixel f%0d: got %0d (%0d,%0d) want %0d (%0d,%0d)",
                       f, pix_data, pix_x, pix_y, exp[28:13], exp[12:6], exp[5:0]);
            end
          end
        end
        if (done_cnt > 0 && !busy) break;
      end
      start = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (done_cnt != 1 || busy !== 1'b0 || pix_valid !== 1'b0 || sb.size() != 0) begin
        miscompares++;
        $display("FAIL start_end f%0d: got %0d pulses busy=%b valid=%b %0d unseen, want 1,0,0,0",
                 f, done_cnt, busy, pix_valid, sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [28:0] exp;
    int h = 0, done_cnt = 0;
    push_frame();
    pix_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < LIM && h < 200; i++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        h++;
        exp = sb.pop_front();
        vectors++;
        if ({pix_data, pix_x, pix_y} !== exp) begin
          miscompares++;
          $display("FAIL rst_pre_pixel: got %0d (%0d,%0d) want %0d", pix_data, pix_x, pix_y, exp[28:13]);
        end
      end
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({pix_valid, busy, pix_x, pix_y, pix_data, mem_addr} !== {2'b00, 7'd0, 6'd0, 16'd0, N'(BASE)}) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got v=%b busy=%b (%0d,%0d) d=%0d addr=%0d, want all reset",
               pix_valid, busy, pix_x, pix_y, pix_data, mem_addr);
    end
    sb.delete();
    @(negedge clk); rstn = 1'b1;
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < LIM; i++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (frame_done) done_cnt++;
      if (pix_valid && pix_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rst_extra: got pixel %0d, want none", pix_data);
        end else begin
          exp = sb.pop_front();
          if ({pix_data, pix_x, pix_y} !== exp) begin
            miscompares++;
            $display("FAIL rst_post_pixel: got %0d (%0d,%0d) want %0d (%0d,%0d)",
                     pix_data, pix_x, pix_y, exp[28:13], exp[12:6], exp[5:0]);
          end
        end
      end
      if (done_cnt > 0 && !busy) break;
    end
    vectors++;
    if (done_cnt != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL rst_post_end: got %0d pulses %0d unseen, want 1 and 0", done_cnt, sb.size());
      sb.delete();
    end
  endtask

`ifdef FRAME_LOOP_EN
  task automatic test_frame_loop();
    logic [28:0] exp;
    int h = 0, cyc = 0, done_cnt = 0;
    repeat (3) push_frame();
    pix_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < 3 * TOTAL + 40; i++) begin
      @(posedge clk); #1;
      start = (h < 2 * TOTAL + TOTAL / 2);
      @(negedge clk);
      if (busy) cyc++;
      if (frame_done) done_cnt++;
      if (pix_valid && pix_ready) begin
        vectors++;
        h++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL loop_extra: got pixel %0d, want none", pix_data);
        end else begin
          exp = sb.pop_front();
          if ({pix_data, pix_x, pix_y} !== exp) begin
            miscompares++;
            $display("FAIL loop_pixel: got %0d (%0d,%0d) want %0d (%0d,%0d)",
                     pix_data, pix_x, pix_y, exp[28:13], exp[12:6], exp[5:0]);
          end
        end
      end
      if (done_cnt >= 3 && !busy) break;
    end
    start = 1'b0;
    vectors++;
    if (cyc != 3 * TOTAL + 2 || done_cnt != 3 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL loop_end: got %0d busy cycles %0d pulses %0d unseen, want %0d, 3, 0",
               cyc, done_cnt, sb.size(), 3 * TOTAL + 2);
      sb.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_handling();
    test_reset_midframe();
`ifdef FRAME_LOOP_EN
    test_frame_loop();
`endif
    vectors++;
    if (rw_bad != 0) begin
      miscompares++;
      $display("FAIL mem_rw_zero: got %0d cycles with mem_rw!=0, want 0", rw_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
